// File: rtl/isp_frame_src_switch.sv
// Frame-synchronous two-source video selector in front of the ISP pipeline.
// Optional WAIT_NEW abort timer is enabled by defining ISP_SWITCH_TIMEOUT_EN.
`timescale 1ns/1ps

module isp_frame_src_switch #(
  parameter int DATA_WIDTH          = 24,
  parameter int PIX_CNT_W           = 22,
  parameter int SWITCH_BLANK_FRAMES = 1,
  parameter int TIMEOUT_CYCLES      = 2000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_sel_i,
  input  logic                  s0_vsync_i,
  input  logic                  s0_valid_i,
  input  logic [DATA_WIDTH-1:0] s0_data_i,
  input  logic                  s1_vsync_i,
  input  logic                  s1_valid_i,
  input  logic [DATA_WIDTH-1:0] s1_data_i,
  output logic                  vsync_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  cur_sel_o,
  output logic                  switch_busy_o,
  output logic [15:0]           frame_cnt_o,
  output logic [PIX_CNT_W-1:0]  last_pix_cnt_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_NEW = 2'd1,
    ST_MUTE     = 2'd2
  } state_t;

  localparam logic [4:0] BLANK = 5'(SWITCH_BLANK_FRAMES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_cur_sel;
  logic                   w_cur_sel_nxt;
  logic [3:0]             r_mute_cnt;
  logic [3:0]             w_mute_cnt_nxt;
  logic                   r_s0_vsync_d;
  logic                   r_s1_vsync_d;
  logic                   w_rise0;
  logic                   w_rise1;
  logic                   w_rise_tgt;
  logic                   w_rise_cur;
  logic                   w_to_fire;
  logic                   w_req_ok;
  logic                   w_mute;
  logic                   w_vs_mux;
  logic                   w_val_mux;
  logic [DATA_WIDTH-1:0]  w_data_mux;
  logic                   w_out_rise;
  logic                   r_vsync_o;
  logic                   r_valid_o;
  logic [DATA_WIDTH-1:0]  r_data_o;
  logic [15:0]            r_frame_cnt;
  logic [PIX_CNT_W-1:0]   r_pix_cnt;
  logic [PIX_CNT_W-1:0]   r_last_pix_cnt;

  assign w_rise0 = s0_vsync_i & ~r_s0_vsync_d;
  assign w_rise1 = s1_vsync_i & ~r_s1_vsync_d;
  // The target is always the source not currently routed.
  assign w_rise_tgt = r_cur_sel ? w_rise0 : w_rise1;
  assign w_rise_cur = r_cur_sel ? w_rise1 : w_rise0;

`ifdef ISP_SWITCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_block;
  logic            r_timeout;
  logic            w_to_abort;

  assign w_to_fire  = (r_state == ST_WAIT_NEW) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_to_abort = w_to_fire && (src_sel_i != r_cur_sel) && !w_rise_tgt;
  assign w_req_ok   = ~r_to_block;
  assign timeout_o  = r_timeout;

  // After an abort the request stays blocked until src_sel_i returns to cur_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt   <= '0;
      r_to_block <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_to_abort;
      if (r_state != ST_WAIT_NEW) r_to_cnt <= '0;
      else                        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_abort)                                      r_to_block <= 1'b1;
      else if (r_state == ST_RUN && src_sel_i == r_cur_sel) r_to_block <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_to_fire        = 1'b0;
  assign w_req_ok         = 1'b1;
  assign timeout_o        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_cur_sel    <= 1'b0;
      r_mute_cnt   <= '0;
      r_s0_vsync_d <= 1'b0;
      r_s1_vsync_d <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      r_state      <= w_state_nxt;
      r_cur_sel    <= w_cur_sel_nxt;
      r_mute_cnt   <= w_mute_cnt_nxt;
      r_s0_vsync_d <= s0_vsync_i;
      r_s1_vsync_d <= s1_vsync_i;
    end
  end

  always_comb begin
    // NOTE: defaults assigned first so every path drives every signal and no latch is inferred.
    w_state_nxt    = r_state;
    w_cur_sel_nxt  = r_cur_sel;
    w_mute_cnt_nxt = r_mute_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (src_sel_i != r_cur_sel && w_req_ok) w_state_nxt = ST_WAIT_NEW;
      end
      ST_WAIT_NEW: begin
        // Cancel outranks a target edge arriving in the same cycle.
        if (src_sel_i == r_cur_sel) begin
          w_state_nxt = ST_RUN;
        end else if (w_rise_tgt) begin
          w_cur_sel_nxt  = ~r_cur_sel;
          w_mute_cnt_nxt = '0;
          w_state_nxt    = (BLANK == 5'd0) ? ST_RUN : ST_MUTE;
        end else if (w_to_fire) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MUTE: begin
        if (w_rise_cur) begin
          if ({1'b0, r_mute_cnt} + 5'd1 == BLANK) w_state_nxt = ST_RUN;
          else                                    w_mute_cnt_nxt = r_mute_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Selecting on the next cur_sel lets the switching vsync edge come from the new source.
  assign w_mute     = (w_state_nxt == ST_MUTE);
  assign w_vs_mux   = w_cur_sel_nxt ? s1_vsync_i : s0_vsync_i;
  assign w_val_mux  = (w_cur_sel_nxt ? s1_valid_i : s0_valid_i) & ~w_mute;
  assign w_data_mux = w_val_mux ? (w_cur_sel_nxt ? s1_data_i : s0_data_i) : '0;
  assign w_out_rise = w_vs_mux & ~r_vsync_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_o      <= 1'b0;
      r_valid_o      <= 1'b0;
      r_data_o       <= '0;
      r_frame_cnt    <= '0;
      r_pix_cnt      <= '0;
      r_last_pix_cnt <= '0;
    end else begin
      r_vsync_o <= w_vs_mux;
      r_valid_o <= w_val_mux;
      r_data_o  <= w_data_mux;
      if (w_out_rise) begin
        r_frame_cnt    <= r_frame_cnt + 16'd1;
        r_last_pix_cnt <= r_pix_cnt;
        r_pix_cnt      <= w_val_mux ? PIX_CNT_W'(1) : '0;
      end else if (w_val_mux && r_pix_cnt != '1) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end

  assign vsync_o        = r_vsync_o;
  assign valid_o        = r_valid_o;
  assign data_o         = r_data_o;
  assign cur_sel_o      = r_cur_sel;
  assign switch_busy_o  = (r_state != ST_RUN);
  assign frame_cnt_o    = r_frame_cnt;
  assign last_pix_cnt_o = r_last_pix_cnt;

endmodule

// File: doc/isp_frame_src_switch.md
Name: isp_frame_src_switch

Overview:
Frame-synchronous source selector and sequencer in front of the ISP video pipeline. It shares one ISP datapath between two same-clock video sources (vsync/valid/data). Source changes take effect only on a frame boundary of the target source, followed by a programmable number of muted frames. It also reports a frame count and the pixel count of the last frame.

Parameters:
DATA_WIDTH, 24, pixel data width (RGB888).
PIX_CNT_W, 22, pixel counter width; enough for 1280x720.
SWITCH_BLANK_FRAMES, 1, number of muted output frames after a switch; 0 to 15.
TIMEOUT_CYCLES, 2000000, WAIT_NEW abort limit; used only with ISP_SWITCH_TIMEOUT_EN.

Ports:
clk  in  1  pixel clock.
rst_n  in  1  asynchronous, active-low reset.
src_sel_i  in  1  requested source, level-sensitive (0 = s0, 1 = s1).
s0_vsync_i  in  1  source 0 vsync, active high.
s0_valid_i  in  1  source 0 pixel valid.
s0_data_i  in  DATA_WIDTH  source 0 pixel.
s1_vsync_i  in  1  source 1 vsync.
s1_valid_i  in  1  source 1 pixel valid.
s1_data_i  in  DATA_WIDTH  source 1 pixel.
vsync_o  out  1  selected vsync, registered.
valid_o  out  1  selected valid, forced 0 while muted.
data_o  out  DATA_WIDTH  selected data, forced 0 when valid_o=0.
cur_sel_o  out  1  source currently routed to the output.
switch_busy_o  out  1  high in WAIT_NEW or MUTE.
frame_cnt_o  out  16  count of output frame starts; wraps 0xFFFF to 0.
last_pix_cnt_o  out  PIX_CNT_W  valid_o count of the previous output frame; saturating.
timeout_o  out  1  one-cycle pulse on WAIT_NEW abort; tied 0 without the macro.

Behaviour:
- Reset: all outputs 0, cur_sel_o=0, state RUN, all counters 0.
- Edge detect: register each source vsync. Rising edge rise_x = sx_vsync_i & ~sx_vsync_d.
- Datapath latency is exactly 1 clk for vsync, valid and data. The mux selects on the combinational next-cur_sel, so the switching edge already comes from the new source.
- RUN:
  - If src_sel_i != cur_sel, go to WAIT_NEW (target = src_sel_i).
  - Output follows cur_sel.
- WAIT_NEW:
  - Output keeps the old source.
  - If src_sel_i == cur_sel, cancel to RUN; no mute; busy drops the next cycle.
  - Else on rise of the target vsync: cur_sel <= target, mute_cnt <= 0. Go to MUTE, or to RUN if SWITCH_BLANK_FRAMES=0.
  - If cancel and target edge occur in the same cycle, cancel wins.
- MUTE:
  - vsync_o follows the new source; valid_o=0, data_o=0.
  - On each rise of the cur_sel vsync: mute_cnt++. When mute_cnt+1 == SWITCH_BLANK_FRAMES, go to RUN; the frame starting at that edge passes unmuted.
  - src_sel_i is ignored in MUTE and re-evaluated in RUN.
- frame_cnt_o increments on each output vsync rising edge, including muted frames.
- Pixel counter:
  - Counts valid_o=1 cycles and saturates at all-ones.
  - On an output vsync rise: last_pix_cnt_o <= count, and the counter restarts (0, or 1 if valid_o is also high that cycle).
  - Muted frames report 0.
- Reset mid-operation returns to RUN with source 0 and clears all counters.

Optional Feature:
ISP_SWITCH_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT_NEW and is cleared on entry.
  - On reaching TIMEOUT_CYCLES with no target edge: return to RUN on the old source and pulse timeout_o for 1 cycle.
  - Request re-arms only after src_sel_i toggles back to cur_sel and away again.
- Undefined: no counter; WAIT_NEW waits indefinitely; timeout_o=0.

Test Plan:
1. Reset: assert rst_n=0 with active inputs -> all outputs 0, cur_sel_o=0; after release, first s0 vsync edge -> frame_cnt_o=1.
2. Passthrough, sel=0: s0 frames of 16 valid pixels (data=0x000001..0x000010) -> outputs equal s0 delayed 1 clk; at the 2nd vsync rise last_pix_cnt_o=16, frame_cnt_o=2; s1 activity has no effect.
3. Switch, SWITCH_BLANK_FRAMES=1:
   - sel=1 mid s0 frame -> switch_busy_o=1 next clk, s0 pixels continue.
   - At s1 vsync rise -> cur_sel_o=1; that frame has valid_o=0 and last_pix_cnt reported 0.
   - Next s1 frame passes all 16 pixels; busy=0.
4. Cancel: sel=1 for 10 clk then 0, with no s1 edge -> cur_sel_o stays 0, busy 1 then 0, no muted frame. Also cover a cancel in the same cycle as the s1 edge -> no switch.
5. Timeout (macro defined, TIMEOUT_CYCLES=100), sel=1 with s1_vsync_i held 0 -> timeout_o pulses once at cycle 100, busy=0, cur_sel_o=0; no re-arm until sel toggles.
6. Wrap and saturation: preload frame_cnt to 0xFFFF -> next edge gives 0; PIX_CNT_W=4 with a 20-pixel frame -> last_pix_cnt_o=15. Reset asserted mid-MUTE -> cur_sel_o=0 and counters 0.
